// File: rtl/operation_encoder_if.sv
// Key-event, race-state and drive-output bundle between the scan-code decoder,
// the operation encoder and the kart physics engine.
interface operation_encoder_if;
  logic       key_valid;
  logic [8:0] key_code;
  logic       key_make;
  logic [2:0] state;
  logic [2:0] operation_code;
  logic       boost;
  logic [7:0] boost_energy;

  modport master (
    output key_valid, key_code, key_make, state,
    input  operation_code, boost, boost_energy
  );

  modport slave (
    input  key_valid, key_code, key_make, state,
    output operation_code, boost, boost_energy
  );
endinterface

// File: rtl/operation_encoder.sv
// Turns PS/2 make/break events into a last-pressed direction code and runs the
// boost energy budget (drain/regen prescaler plus READY/ON/LOCK lockout FSM).
module operation_encoder #(
  parameter logic [8:0] KEY_UP      = 9'h01D,
  parameter logic [8:0] KEY_DOWN    = 9'h01B,
  parameter logic [8:0] KEY_LEFT    = 9'h01C,
  parameter logic [8:0] KEY_RIGHT   = 9'h023,
  parameter logic [8:0] KEY_BOOST   = 9'h029,
  parameter int         ENERGY_MAX  = 200,
  parameter int         REARM_LEVEL = 50,
  parameter int         TICK_DIV    = 1_000_000
) (
  input logic                clk,
  input logic                rst,
  operation_encoder_if.slave bus
);

  localparam logic [2:0] ST_RACING = 3'd4;
  localparam logic [2:0] ST_PAUSE  = 3'd5;
  localparam logic [2:0] ST_FINISH = 3'd6;

  localparam logic [2:0] OP_NIL   = 3'd0;
  localparam logic [2:0] OP_UP    = 3'd1;
  localparam logic [2:0] OP_DOWN  = 3'd2;
  localparam logic [2:0] OP_LEFT  = 3'd3;
  localparam logic [2:0] OP_RIGHT = 3'd4;

  localparam int                PRESC_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [7:0]        ENERGY_FULL = 8'(ENERGY_MAX);
  localparam logic [7:0]        ENERGY_REARM = 8'(REARM_LEVEL);

  typedef enum logic [1:0] {
    B_READY = 2'd0,
    B_ON    = 2'd1,
    B_LOCK  = 2'd2
  } boost_state_e;

  // held bit order: [4] up, [3] down, [2] left, [1] right, [0] boost
  logic [4:0]         held_r, held_next_s, hit_s;
  logic [2:0]         last_dir_r, last_dir_next_s, hit_dir_s;
  logic [2:0]         operation_code_r;
  logic               boost_r;
  logic [7:0]         energy_r, energy_next_s;
  logic [PRESC_W-1:0] presc_r, presc_next_s;
  logic               tick_s;
  logic               boost_held_s, dir_active_s;
  boost_state_e       fsm_r, fsm_next_s;

  // Fixed-priority pick of a direction from an {up,down,left,right} set.
  function automatic logic [2:0] pick_dir(input logic [3:0] dirs);
    if (dirs[3]) begin
      return OP_UP;
    end else if (dirs[2]) begin
      return OP_DOWN;
    end else if (dirs[1]) begin
      return OP_LEFT;
    end else if (dirs[0]) begin
      return OP_RIGHT;
    end else begin
      return OP_NIL;
    end
  endfunction

  // Key decode: held-set update and last-pressed direction selection.
  always_comb begin
    hit_s           = 5'b00000;
    held_next_s     = held_r;
    last_dir_next_s = last_dir_r;
    if (bus.key_valid) begin
      hit_s = {bus.key_code == KEY_UP,   bus.key_code == KEY_DOWN,
               bus.key_code == KEY_LEFT, bus.key_code == KEY_RIGHT,
               bus.key_code == KEY_BOOST};
    end else begin
      hit_s = 5'b00000;
    end
    if (bus.key_make) begin
      held_next_s = held_r | hit_s;
    end else begin
      held_next_s = held_r & ~hit_s;
    end
    hit_dir_s = pick_dir(hit_s[4:1]);
    if (hit_dir_s == OP_NIL) begin
      last_dir_next_s = last_dir_r;
    end else if (bus.key_make) begin
      last_dir_next_s = hit_dir_s;
    end else if (hit_dir_s == last_dir_r) begin
      // Releasing the active direction falls back to whatever is still held.
      last_dir_next_s = pick_dir(held_next_s[4:1]);
    end else begin
      last_dir_next_s = last_dir_r;
    end
  end

  // Prescaler next count: runs while racing, frozen while paused/finished.
  always_comb begin
    presc_next_s = presc_r;
    tick_s       = (bus.state == ST_RACING) && (presc_r == PRESC_LAST);
    case (bus.state)
      ST_RACING: begin
        if (tick_s) begin
          presc_next_s = '0;
        end else begin
          presc_next_s = presc_r + PRESC_W'(1);
        end
      end
      ST_PAUSE, ST_FINISH: presc_next_s = presc_r;
      default:             presc_next_s = '0;
    endcase
  end

  // Boost FSM next state and energy budget, both from pre-edge values.
  always_comb begin
    fsm_next_s    = fsm_r;
    energy_next_s = energy_r;
    boost_held_s  = held_r[0];
    dir_active_s  = (last_dir_r != OP_NIL);
    case (bus.state)
      ST_RACING: begin
        case (fsm_r)
          B_READY: begin
            if (boost_held_s && dir_active_s && (energy_r != 8'd0)) begin
              fsm_next_s = B_ON;
            end else begin
              fsm_next_s = B_READY;
            end
          end
          B_ON: begin
            if (tick_s && (energy_r == 8'd1)) begin
              fsm_next_s = B_LOCK;
            end else if (!boost_held_s || !dir_active_s) begin
              fsm_next_s = B_READY;
            end else begin
              fsm_next_s = B_ON;
            end
          end
          B_LOCK: begin
            if (!boost_held_s && (energy_r >= ENERGY_REARM)) begin
              fsm_next_s = B_READY;
            end else begin
              fsm_next_s = B_LOCK;
            end
          end
          default: fsm_next_s = B_READY;
        endcase
        if (!tick_s) begin
          energy_next_s = energy_r;
        end else if (fsm_r == B_ON) begin
          if (energy_r != 8'd0) begin
            energy_next_s = energy_r - 8'd1;
          end else begin
            energy_next_s = energy_r;
          end
        end else if (!boost_held_s && (energy_r < ENERGY_FULL)) begin
          energy_next_s = energy_r + 8'd1;
        end else begin
          energy_next_s = energy_r;
        end
      end
      ST_PAUSE, ST_FINISH: begin
        energy_next_s = energy_r;
        case (fsm_r)
          B_ON:    fsm_next_s = B_READY;
          B_LOCK:  fsm_next_s = B_LOCK;
          default: fsm_next_s = B_READY;
        endcase
      end
      default: begin
        fsm_next_s    = B_READY;
        energy_next_s = ENERGY_FULL;
      end
    endcase
  end

  // Key tracking and gated operation code registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_r           <= 5'b00000;
      last_dir_r       <= OP_NIL;
      operation_code_r <= OP_NIL;
    end else begin
      held_r           <= held_next_s;
      last_dir_r       <= last_dir_next_s;
      operation_code_r <= (bus.state == ST_RACING) ? last_dir_r : OP_NIL;
    end
  end

  // Boost FSM, energy, prescaler and registered boost flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r    <= B_READY;
      energy_r <= ENERGY_FULL;
      presc_r  <= '0;
      boost_r  <= 1'b0;
    end else begin
      fsm_r    <= fsm_next_s;
      energy_r <= energy_next_s;
      presc_r  <= presc_next_s;
      boost_r  <= (fsm_next_s == B_ON);
    end
  end

  assign bus.operation_code = operation_code_r;
  assign bus.boost          = boost_r;
  assign bus.boost_energy   = energy_r;

endmodule

// File: doc/operation_encoder.md
# operation_encoder

Converts PS/2 key make/break events into the per-cycle `operation_code` and `boost` signals consumed by the kart physics engine. It tracks held direction keys with last-pressed priority. It also owns the boost-energy budget: a drain/regen counter with a lockout FSM. The block sits between the keyboard scan-code decoder and the physics engine, and is gated by the global race state from the state encoder.

## Interface
Parameters:
- `KEY_UP`, default 9'h01D (W): `{extended, scan_code}` for UP.
- `KEY_DOWN`, default 9'h01B (S): scan code for DOWN.
- `KEY_LEFT`, default 9'h01C (A): scan code for LEFT.
- `KEY_RIGHT`, default 9'h023 (D): scan code for RIGHT.
- `KEY_BOOST`, default 9'h029 (Space): scan code for boost.
- `ENERGY_MAX`, default 200: full energy value (≤255).
- `REARM_LEVEL`, default 50: energy required to leave lockout.
- `TICK_DIV`, default 1_000_000: clk cycles per energy tick.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high. Reset rst, synchronous, active-high; clock clk.
- `key_valid`  in  1  one-cycle strobe; at most one key event per cycle.
- `key_code`  in  9  `{extended, scan_code}` of the event.
- `key_make`  in  1  1 = press (make), 0 = release (break).
- `state`  in  3  race state: IDLE 0, SETTING 1, COUNTDOWN 3, RACING 4, PAUSE 5, FINISH 6.
- `operation_code`  out  3  NIL 0, UP 1, DOWN 2, LEFT 3, RIGHT 4; registered.
- `boost`  out  1  boost active; registered.
- `boost_energy`  out  8  current energy, for the HUD.

## Operation
- Held-key registers: 5 bits, one per key (U/D/L/R/B).
  - On `key_valid` with a matching code: set the bit on make, clear it on break.
  - Non-matching codes are ignored.
  - Tracking runs in every state.
- Last-direction register `last_dir`:
  - Any direction make, including typematic repeats, loads that direction.
  - Break of the direction currently in `last_dir` reloads `last_dir` from the held set in fixed priority UP > DOWN > LEFT > RIGHT, or NIL if none is held.
  - Break of any other key leaves `last_dir` unchanged.
- `operation_code`: equals `last_dir` when `state == RACING`, otherwise NIL.
- Prescaler:
  - Counts 0..TICK_DIV-1 in RACING; `tick` is asserted when the count equals TICK_DIV-1, then the count wraps to 0.
  - Holds in PAUSE and FINISH.
  - Clears to 0 in IDLE, SETTING and COUNTDOWN.
- Boost FSM states: READY, ON, LOCK.
  - READY → ON when RACING, boost held, `last_dir != NIL` and energy > 0.
  - ON → LOCK when a tick decrements energy to 0. This takes priority over ON → READY.
  - ON → READY when boost is released, `last_dir == NIL`, or state != RACING.
  - LOCK → READY when boost is not held and energy ≥ REARM_LEVEL.
- Energy update, applied only on `tick`:
  - In ON: energy − 1.
  - Otherwise, if boost is not held and energy < ENERGY_MAX: energy + 1 (saturating).
  - Energy never underflows or overflows.
- In IDLE, SETTING and COUNTDOWN: energy reloads to ENERGY_MAX and the FSM goes to READY every cycle.
- In PAUSE and FINISH: energy and FSM are frozen, except that ON → READY still occurs.
- `boost` is 1 iff the FSM is in ON.

## Timing
- Reset values:
  - Held bits 0, `last_dir` NIL, `operation_code` 0, `boost` 0.
  - `boost_energy` = ENERGY_MAX, FSM READY, prescaler 0.
- `rst` overrides any in-progress event or boost.
- Key event in cycle N:
  - Held/`last_dir` update on the edge ending N.
  - `operation_code` reflects it after the edge ending N+1, i.e. 2-edge latency.
- State change in cycle N: `operation_code` is gated after the edge ending N (1-edge latency).
- `boost` follows the FSM register directly: 1 edge after its transition condition.
- `boost_energy` changes on the edge ending the tick cycle.
- A FSM transition and an energy update in the same cycle both use pre-edge values.

## Test plan
- Reset: assert rst 2 cycles → `operation_code` = 0, `boost` = 0, `boost_energy` = 200.
- Direction priority, with state = 4:
  - make W → `operation_code` = 1 two edges later.
  - make D → 4.
  - break D → 1.
  - break W → 0.
  - make A, make S, break S → 3.
- State gating:
  - state = 1, make W → `operation_code` stays 0.
  - state → 4 → `operation_code` = 1 after one edge.
  - state → 5 → 0.
- Drain and lockout, with TICK_DIV = 4, ENERGY_MAX = 8, REARM_LEVEL = 4, state = 4:
  - hold W + Space → `boost` = 1; energy decrements 1 per 4 cycles.
  - energy reaches 0 → `boost` = 0; still 0 with Space held.
  - release Space → energy +1 per tick.
  - re-press Space at energy 3 → `boost` = 0.
  - re-press at energy ≥ 4 → `boost` = 1.
- Pause freeze, with state 4 → 5 mid-boost:
  - `boost` = 0, energy and prescaler constant over 20 cycles.
  - back to 4 → drain resumes from the same energy and prescaler count.
- Robustness:
  - key_code 9'h042 make/break → no output change.
  - rst asserted while `boost` = 1 → all outputs at reset values next edge.
